// File: rtl/cpu_phase_seq_pkg.sv
// Shared definitions for the cpu65CE02 phase sequencer and its bus-region decode.
// State encoding, default wait-state constants and the IO region compare helper.
package cpu_phase_seq_pkg;

  typedef enum logic [2:0] {
    SEQ_RESET = 3'd0,
    SEQ_PH1   = 3'd1,
    SEQ_PH2   = 3'd2,
    SEQ_PH3   = 3'd3,
    SEQ_WAIT  = 3'd4,
    SEQ_HALT  = 3'd5
  } seq_state_e;

  localparam int unsigned DEFAULT_MEM_WS   = 0;
  localparam int unsigned DEFAULT_IO_WS    = 3;
  localparam int unsigned DEFAULT_RST_HOLD = 4;
  localparam logic [15:0] DEFAULT_IO_BASE  = 16'hD000;
  localparam logic [15:0] DEFAULT_IO_MASK  = 16'hF000;

  function automatic logic in_io_region(input logic [15:0] addr,
                                        input logic [15:0] base,
                                        input logic [15:0] mask);
    return (addr & mask) == (base & mask);
  endfunction

endpackage

// File: rtl/cpu_ws_decode.sv
// Region compare: wait-state count for a bus address.
// Purely combinational so the bus arbiter can reuse it in its own pipeline.
module cpu_ws_decode
  import cpu_phase_seq_pkg::*;
#(
  parameter int unsigned MEM_WS  = DEFAULT_MEM_WS,
  parameter int unsigned IO_WS   = DEFAULT_IO_WS,
  parameter logic [15:0] IO_BASE = DEFAULT_IO_BASE,
  parameter logic [15:0] IO_MASK = DEFAULT_IO_MASK
) (
  input  logic [15:0] address,
  output logic [3:0]  wait_states
);

  assign wait_states = in_io_region(address, IO_BASE, IO_MASK) ? 4'(IO_WS) : 4'(MEM_WS);

endmodule

// File: rtl/cpu_phase_seq.sv
// Phase sequencer for cpu65CE02: phi1/phi2/phi3 strobes, per-region wait
// states, memory-ready stretch, run/halt/step control and a phi2 cycle counter.
module cpu_phase_seq
  import cpu_phase_seq_pkg::*;
#(
  parameter int unsigned MEM_WS   = DEFAULT_MEM_WS,
  parameter int unsigned IO_WS    = DEFAULT_IO_WS,
  parameter logic [15:0] IO_BASE  = DEFAULT_IO_BASE,
  parameter logic [15:0] IO_MASK  = DEFAULT_IO_MASK,
  parameter int unsigned RST_HOLD = DEFAULT_RST_HOLD,
  // Reset value of cycle_count; nonzero only to exercise wrap-around in simulation.
  parameter logic [31:0] CNT_INIT = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address_next,
  input  logic        write_next,
  input  logic        sync,
  input  logic        mem_ready,
  input  logic        run,
  input  logic        step,
  output logic        phi1,
  output logic        phi2,
  output logic        phi3,
  output logic        mem_req,
  output logic        mem_we,
  output logic        halted,
  output logic [31:0] cycle_count
);

  seq_state_e  state;
  logic [3:0]  hold_cnt;
  logic [3:0]  wait_cnt;
  logic [3:0]  next_ws;
  logic        step_latch;
  logic        stop_req;

  cpu_ws_decode #(
    .MEM_WS  (MEM_WS),
    .IO_WS   (IO_WS),
    .IO_BASE (IO_BASE),
    .IO_MASK (IO_MASK)
  ) u_ws_decode (
    .address     (address_next),
    .wait_states (next_ws)
  );

  // NOTE: every register here uses <= so all state updates see pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= SEQ_RESET;
      hold_cnt    <= 4'(RST_HOLD);
      wait_cnt    <= 4'd0;
      step_latch  <= 1'b0;
      stop_req    <= 1'b0;
      phi1        <= 1'b0;
      phi2        <= 1'b0;
      phi3        <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      halted      <= 1'b0;
      cycle_count <= CNT_INIT;
    end else begin
      // Strobes are one-clock pulses: low unless the transition below raises one.
      phi1    <= 1'b0;
      phi2    <= 1'b0;
      phi3    <= 1'b0;
      mem_req <= 1'b0;

      case (state)
        SEQ_RESET: begin
          if (hold_cnt == 4'd0) begin
            state <= SEQ_PH1;
            phi1  <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - 4'd1;
          end
        end

        SEQ_PH1: begin
          state <= SEQ_PH2;
          phi2  <= 1'b1;
        end

        SEQ_PH2: begin
          mem_we      <= write_next;
          wait_cnt    <= next_ws;
          cycle_count <= cycle_count + 32'd1;
          if (sync && step_latch) begin
            step_latch <= 1'b0;
            stop_req   <= 1'b1;
          end
          state   <= SEQ_PH3;
          phi3    <= 1'b1;
          mem_req <= 1'b1;
        end

        SEQ_PH3: begin
          state <= SEQ_WAIT;
        end

        SEQ_WAIT: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else if (mem_ready) begin
            // A pending step keeps cycling with run low until its fetch completes.
            if (stop_req || (!run && !step_latch)) begin
              state    <= SEQ_HALT;
              halted   <= 1'b1;
              stop_req <= 1'b0;
            end else begin
              state <= SEQ_PH1;
              phi1  <= 1'b1;
            end
          end
        end

        SEQ_HALT: begin
          if (run) begin
            state    <= SEQ_PH1;
            phi1     <= 1'b1;
            halted   <= 1'b0;
            stop_req <= 1'b0;
          end else if (step) begin
            state      <= SEQ_PH1;
            phi1       <= 1'b1;
            halted     <= 1'b0;
            step_latch <= 1'b1;
          end
        end

        default: state <= SEQ_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_phase_seq.sv
// Directed bench for cpu_phase_seq: reset hold, strobe timing, wait states,
// mem_ready stretch, run/halt/step, mid-cycle reset and counter wrap.
module tb_cpu_phase_seq;

  logic        clk;
  logic        reset;
  logic [15:0] address_next;
  logic        write_next;
  logic        sync;
  logic        mem_ready;
  logic        run;
  logic        step;
  logic        phi1, phi2, phi3, mem_req, mem_we, halted;
  logic [31:0] cycle_count;
  logic        w_phi1, w_phi2, w_phi3, w_mem_req, w_mem_we, w_halted;
  logic [31:0] w_cycle_count;

  int checks   = 0;
  int failures = 0;
  int n, req, np, k;

  cpu_phase_seq #(
    .MEM_WS(0), .IO_WS(3), .IO_BASE(16'hD000), .IO_MASK(16'hF000), .RST_HOLD(4)
  ) dut (
    .clk(clk), .reset(reset), .address_next(address_next), .write_next(write_next),
    .sync(sync), .mem_ready(mem_ready), .run(run), .step(step),
    .phi1(phi1), .phi2(phi2), .phi3(phi3), .mem_req(mem_req), .mem_we(mem_we),
    .halted(halted), .cycle_count(cycle_count)
  );

  cpu_phase_seq #(
    .MEM_WS(0), .IO_WS(3), .IO_BASE(16'hD000), .IO_MASK(16'hF000), .RST_HOLD(4),
    .CNT_INIT(32'hFFFF_FFFE)
  ) dut_wrap (
    .clk(clk), .reset(reset), .address_next(address_next), .write_next(write_next),
    .sync(sync), .mem_ready(mem_ready), .run(run), .step(step),
    .phi1(w_phi1), .phi2(w_phi2), .phi3(w_phi3), .mem_req(w_mem_req), .mem_we(w_mem_we),
    .halted(w_halted), .cycle_count(w_cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] strobes();
    return {phi1, phi2, phi3, mem_req};
  endfunction

  // Tick until phi1, holding mem_ready low for the first 'lo' ticks; bounded.
  task automatic wait_phi1(input int lo, output int ticks, output int reqs);
    ticks = 0;
    reqs  = 0;
    if (lo > 0) mem_ready = 1'b0;
    while (ticks < 40) begin
      tick();
      ticks++;
      if (mem_req) reqs++;
      if (ticks == lo) mem_ready = 1'b1;
      if (phi1) break;
    end
    mem_ready = 1'b1;
  endtask

  initial begin
    reset = 1'b0; run = 1'b1; mem_ready = 1'b1; address_next = 16'h0000;
    write_next = 1'b0; sync = 1'b0; step = 1'b0;
    repeat (2) tick();
    check("rst_strobes", 32'(strobes()), 32'h0);
    check("rst_count", cycle_count, 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);

    // Reset hold: first phi1 on the fifth edge after release.
    reset = 1'b1;
    repeat (4) tick();
    check("hold_no_phi1", 32'(strobes()), 32'h0);
    tick();
    check("first_phi1", 32'(strobes()), 32'b1000);

    for (int c = 1; c <= 3; c++) begin
      tick();
      check($sformatf("ph2_%0d", c), 32'(strobes()), 32'b0100);
      tick();
      check($sformatf("ph3_%0d", c), 32'(strobes()), 32'b0011);
      check($sformatf("count_%0d", c), cycle_count, 32'(c));
      check($sformatf("wrap_count_%0d", c), w_cycle_count, 32'hFFFF_FFFE + 32'(c));
      check($sformatf("wrap_strobes_%0d", c),
            32'({w_phi1, w_phi2, w_phi3, w_mem_req, w_mem_we, w_halted}), 32'b001100);
      tick();
      check($sformatf("wait_%0d", c), 32'(strobes()), 32'h0);
      tick();
      check($sformatf("ph1_%0d", c), 32'(strobes()), 32'b1000);
    end

    // IO-region write cycle: 3 wait states, period 7.
    address_next = 16'hD020; write_next = 1'b1;
    tick();
    check("io_ph2", 32'(strobes()), 32'b0100);
    tick();
    check("io_ph3", 32'(strobes()), 32'b0011);
    check("io_mem_we", 32'(mem_we), 32'h1);
    address_next = 16'h0000; write_next = 1'b0;
    wait_phi1(0, n, req);
    check("io_period", 32'(n + 2), 32'd7);
    check("io_req_once", 32'(req), 32'd0);
    check("io_we_held", 32'(mem_we), 32'h1);

    // Normal read, mem_ready low for 5 clocks from phi3: phi1 six clocks later.
    tick();
    tick();
    check("we_cleared", 32'(mem_we), 32'h0);
    wait_phi1(5, n, req);
    check("ready_low_period", 32'(n), 32'd6);

    // IO cycle with mem_ready low only while counting down: no added delay.
    address_next = 16'hD020;
    tick();
    tick();
    address_next = 16'h0000;
    wait_phi1(3, n, req);
    check("io_ready_hidden", 32'(n), 32'd5);

    // run dropped in PH2: cycle completes, then park. Step while running is ignored.
    tick();
    run = 1'b0;
    tick();
    check("run_drop_ph3", 32'(strobes()), 32'b0011);
    tick();
    check("no_halt_midcycle", 32'(halted), 32'h0);
    step = 1'b1;
    tick();
    step = 1'b0;
    check("halt_entered", 32'(halted), 32'h1);
    check("halt_strobes", 32'(strobes()), 32'h0);
    check("halt_count", cycle_count, 32'd7);
    repeat (3) tick();
    check("halt_parked", 32'({halted, strobes()}), 32'b10000);

    run = 1'b1;
    tick();
    check("resume_ph1", 32'({halted, strobes()}), 32'b01000);
    run = 1'b0;
    repeat (4) tick();
    check("rehalt", 32'(halted), 32'h1);
    check("rehalt_count", cycle_count, 32'd8);

    // Single step: three cycles, fetch on the fourth phi2, then park.
    step = 1'b1;
    tick();
    step = 1'b0;
    check("step_ph1", 32'({halted, strobes()}), 32'b01000);
    np = 0;
    for (k = 0; k < 80; k++) begin
      tick();
      if (phi2) begin
        np++;
        sync = (np == 4);
      end else begin
        sync = 1'b0;
      end
      if (halted) break;
    end
    check("step_phi2s", 32'(np), 32'd4);
    check("step_len", 32'(k + 1), 32'd16);
    check("step_count", cycle_count, 32'd12);
    repeat (4) tick();
    check("step_parked", 32'({halted, strobes()}), 32'b10000);

    // run and step together: free run, no pending stop even with sync high.
    sync = 1'b1; run = 1'b1; step = 1'b1;
    tick();
    step = 1'b0;
    check("run_wins_ph1", 32'({halted, strobes()}), 32'b01000);
    repeat (12) tick();
    check("free_run", 32'({halted, strobes()}), 32'b01000);
    check("free_run_count", cycle_count, 32'd15);
    sync = 1'b0;

    // Asynchronous reset while in WAIT of an IO cycle.
    address_next = 16'hD020; write_next = 1'b1;
    tick();
    tick();
    check("abort_pre_we", 32'(mem_we), 32'h1);
    address_next = 16'h0000; write_next = 1'b0;
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    check("abort_strobes", 32'({halted, strobes()}), 32'h0);
    check("abort_count", cycle_count, 32'h0);
    check("abort_mem_we", 32'(mem_we), 32'h0);
    reset = 1'b1;
    repeat (4) tick();
    check("rerelease_hold", 32'(strobes()), 32'h0);
    tick();
    check("rerelease_phi1", 32'(strobes()), 32'b1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_phase_seq.md
Name: cpu_phase_seq

Overview:
- Phase sequencer directly upstream of cpu65CE02. Generates the one-clock phi1/phi2/phi3 enable strobes that advance the core.
- Stretches each CPU bus cycle with per-region wait states and an external memory-ready handshake.
- Supports monitor run/halt and single-instruction stepping.
- Exports a free-running CPU cycle counter.

Parameters:
- MEM_WS, 0, wait clocks inserted after phi3 for normal addresses (0..15).
- IO_WS, 3, wait clocks for addresses that match the IO region (0..15).
- IO_BASE, 16'hD000, base of the IO region.
- IO_MASK, 16'hF000, address bits compared against IO_BASE.
- RST_HOLD, 4, clocks held in RESET state after reset deasserts (1..15).

Ports:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous, active-low.
- address_next, in, 16, core's next bus address; valid while phi2 is high.
- write_next, in, 1, core's next-cycle write flag; valid while phi2 is high.
- sync, in, 1, core opcode-fetch indicator for the current cycle.
- mem_ready, in, 1, memory-side level ready; low stretches the cycle.
- run, in, 1, 1 = free run; 0 = halt at the next cycle boundary.
- step, in, 1, single-clock pulse; while halted, executes one instruction.
- phi1, out, 1, phase-1 strobe.
- phi2, out, 1, phase-2 strobe.
- phi3, out, 1, phase-3 strobe.
- mem_req, out, 1, one-clock pulse coincident with phi3: a bus cycle starts.
- mem_we, out, 1, write_next captured at phi2; held until the next phi2.
- halted, out, 1, sequencer is parked at a cycle boundary.
- cycle_count, out, 32, number of phi2 strobes since reset; wraps.

Behaviour:
- States: RESET, PH1, PH2, PH3, WAIT, HALT. Encoding is one-hot or binary, implementer's choice.
- Reset asserted (reset=0), asynchronous: state=RESET; hold counter=RST_HOLD; phi1/phi2/phi3/mem_req=0; mem_we=0; cycle_count=0; halted=0; wait counter=0; step latch=0.
- RESET: hold counter decrements once per clock after reset deasserts. At 0 go to PH1, ignoring run. The first CPU cycle always executes.
- PH1: phi1=1 for exactly one clock. Next state PH2.
- PH2: phi2=1 for one clock.
  - Capture write_next into mem_we.
  - Load wait counter with IO_WS if (address_next & IO_MASK)==(IO_BASE & IO_MASK), else MEM_WS.
  - Increment cycle_count.
  - If sync=1 and the step latch is set, clear the step latch and set the stop-request flag.
  - Next state PH3.
- PH3: phi3=1 and mem_req=1 for one clock. Next state WAIT.
- WAIT: decrement the wait counter while it is nonzero.
  - The cycle boundary is reached when the counter is 0 and mem_ready=1, sampled in the same clock. With 0 wait states, WAIT lasts exactly 1 clock if mem_ready=1.
  - At the boundary: go to HALT if run=0 or the stop-request flag is set (flag clears on entry); else go to PH1.
- Minimum CPU cycle is 4 clocks (PH1, PH2, PH3, WAIT). Each wait state adds 1 clock. A low mem_ready adds 1 clock per low sample once the counter is 0.
- mem_ready is ignored while the wait counter is nonzero.
- HALT: halted=1 and no strobes.
  - Leave to PH1 when run=1. The stop-request flag is cleared.
  - Leave to PH1 when step=1. Set the step latch.
  - If run=1 and step=1 arrive in the same clock, run wins and the step latch stays clear.
  - halted drops in the clock that PH1 is entered.
- Step semantics: the sequencer runs cycles until the PH2 of a cycle with sync=1 (the next opcode fetch). It then completes that cycle and halts, leaving the core parked after the fetch's phi2. A step issued while not halted is ignored.
- run is sampled only at a cycle boundary. Deasserting run mid-cycle never truncates a cycle.
- phi1, phi2 and phi3 are mutually exclusive and each is exactly one clock wide.
- cycle_count wraps from 32'hFFFFFFFF to 0 with no flag.
- An asynchronous reset mid-cycle aborts the cycle immediately, with all outputs at their reset values.
- All outputs are registered. No combinational path from any input to any output.

Decomposition:
- Shared package (65ce02_inc.vh): state encodings (kSEQ_RESET .. kSEQ_HALT) and the default wait-state constants.
- One natural sub-module, cpu_ws_decode: combinational region compare that returns a 4-bit wait count from address_next and the parameters. It is reused by later bus-arbiter work.

Test Plan:
- Reset release, RST_HOLD=4, run=1, mem_ready=1, MEM_WS=0 -> first phi1 at clock 5 after reset rises. Strobes repeat phi1, phi2, phi3, idle with period 4. cycle_count=3 after the third phi2.
- address_next=16'hD020 at phi2, IO_WS=3 -> period of that cycle = 7 clocks; mem_req pulses exactly once with phi3; mem_we equals write_next sampled at phi2.
- MEM_WS=0, mem_ready held low 5 clocks after phi3 -> next phi1 arrives 6 clocks after phi3. With IO_WS=3 and mem_ready low only during the first 2 wait clocks -> no extra delay.
- run dropped during PH2 -> cycle completes and halted=1 at the boundary with no further strobes. run=1 -> phi1 in the next clock and halted=0.
- Halted, step pulse, instruction of 3 cycles, sync=1 at the fourth cycle's phi2 -> exactly 4 phi2 strobes, then halted=1. Step and run raised in the same clock -> free run continues.
- Assert reset during WAIT with IO_WS=3 -> all strobes 0 immediately and cycle_count=0. cycle_count preset near 32'hFFFFFFFF -> wraps to 0 with no glitch on phi strobes.
